// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, reset constants and word type for pipeline stage registers
package pipe_pkg;
  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_PC_W   = 32;
  localparam logic [PIPE_PC_W-1:0]   PIPE_RESET_PC = '0;
  localparam logic [PIPE_DATA_W-1:0] PIPE_NOP_WORD = '0;
  typedef struct packed {
    logic [PIPE_PC_W-1:0]   pc;
    logic [PIPE_DATA_W-1:0] data;
  } pipe_word_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry main/skid storage; skid catches a word accepted while main is full and not draining
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int PC_W   = PIPE_PC_W,
  parameter logic [PC_W-1:0]   RESET_PC = PC_W'(PIPE_RESET_PC),
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(PIPE_NOP_WORD)
) (
  input  logic              clk,
  input  logic              res,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_main_valid,
  output logic              o_skid_valid,
  output logic [PC_W-1:0]   o_pc,
  output logic [DATA_W-1:0] o_data
);
  logic              r_main_valid, r_skid_valid;
  logic [PC_W-1:0]   r_main_pc, r_skid_pc;
  logic [DATA_W-1:0] r_main_data, r_skid_data;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_pc    <= RESET_PC;
      r_main_data  <= NOP_WORD;
      r_skid_pc    <= RESET_PC;
      r_skid_data  <= NOP_WORD;
    end else if (i_clr) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_pc    <= RESET_PC;
      r_main_data  <= NOP_WORD;
    end else if (i_push && (!r_main_valid || i_pop)) begin
      r_main_valid <= 1'b1;
      r_main_pc    <= i_pc;
      r_main_data  <= i_data;
    end else if (i_push) begin
      r_skid_valid <= 1'b1;
      r_skid_pc    <= i_pc;
      r_skid_data  <= i_data;
    end else if (i_pop && r_skid_valid) begin
      r_skid_valid <= 1'b0;
      r_main_pc    <= r_skid_pc;
      r_main_data  <= r_skid_data;
    end else if (i_pop) begin
      r_main_valid <= 1'b0;
    end
  end

  assign o_main_valid = r_main_valid;
  assign o_skid_valid = r_skid_valid;
  assign o_pc         = r_main_pc;
  assign o_data       = r_main_data;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with stall/flush and saturating stall counter; PIPE_STAGE_SKID_EN adds a skid entry
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int PC_W   = PIPE_PC_W,
  parameter logic [PC_W-1:0]   RESET_PC = PC_W'(PIPE_RESET_PC),
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(PIPE_NOP_WORD),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              r_live;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_valid, w_in_fire, w_out_fire;
  logic [PC_W-1:0]   w_pc;
  logic [DATA_W-1:0] w_data;

  // r_live keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge res) begin
    if (!res) r_live <= 1'b0;
    else      r_live <= 1'b1;
  end

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign out_valid  = w_valid & ~stall & ~flush;

`ifdef PIPE_STAGE_SKID_EN
  logic w_skid_valid;

  pipe_skid_buf #(
    .DATA_W(DATA_W), .PC_W(PC_W), .RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)
  ) u_buf (
    .clk         (clk),
    .res         (res),
    .i_clr       (flush),
    .i_push      (w_in_fire & ~flush & ~stall),
    .i_pop       (w_out_fire),
    .i_pc        (in_pc),
    .i_data      (in_data),
    .o_main_valid(w_valid),
    .o_skid_valid(w_skid_valid),
    .o_pc        (w_pc),
    .o_data      (w_data)
  );

  assign in_ready = r_live & (flush | (~stall & ~w_skid_valid));
`else
  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_valid <= 1'b0;
      r_pc    <= RESET_PC;
      r_data  <= NOP_WORD;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_pc    <= RESET_PC;
      r_data  <= NOP_WORD;
    end else if (!stall && w_in_fire) begin
      r_valid <= 1'b1;
      r_pc    <= in_pc;
      r_data  <= in_data;
    end else if (!stall && w_out_fire) begin
      r_valid <= 1'b0;
    end
  end

  assign w_valid  = r_valid;
  assign w_pc     = r_pc;
  assign w_data   = r_data;
  assign in_ready = r_live & (flush | (~stall & (~r_valid | out_ready)));
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res)
      r_stall_cnt <= '0;
    else if (stall && w_valid && !flush && !(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign out_pc    = w_pc;
  assign out_data  = w_data;
  assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of reset, streaming, backpressure, stall, flush and counter saturation
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready_s;
  logic [31:0] in_pc = '0;
  logic [31:0] in_data = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid, out_valid_s;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_pc_s;
  logic [31:0] out_data, out_data_s;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt_s;
  int          n_err = 0;
  int          n_chk = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_data(in_data), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_data(out_data), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_pc(in_pc), .in_data(in_data), .stall(stall), .flush(flush),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_pc(out_pc_s),
    .out_data(out_data_s), .stall_cnt(stall_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = 1'b1;
    in_pc    = 32'h3000;
    repeat (3) tick;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    in_valid = 1'b0;
    res = 1'b1;
    #1 chk("rel_in_ready_same", in_ready, 0);
    tick;
    chk("rel_in_ready_next", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h3000 + 32'(4 * i);
      in_data  = 32'hA000_0000 + 32'(i);
      #1 chk("str_in_ready", in_ready, 1);
      tick;
      chk("str_out_valid", out_valid, 1);
      chk("str_out_pc", out_pc, 32'h3000 + 32'(4 * i));
      chk("str_out_data", out_data, 32'hA000_0000 + 32'(i));
    end
    in_valid = 1'b0;
    tick;
    chk("str_drain", out_valid, 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h3000;
    in_data   = 32'hB0;
    #1 chk("bp_accept0", in_ready, 1);
    tick;
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_pc", out_pc, 32'h3000);
    in_pc   = 32'h3004;
    in_data = 32'hB4;
`ifdef PIPE_STAGE_SKID_EN
    #1 chk("bp_skid_accept", in_ready, 1);
    tick;
    in_valid = 1'b0;
    #1 chk("bp_full", in_ready, 0);
    tick;
`else
    #1 chk("bp_blocked", in_ready, 0);
    tick;
    #1 chk("bp_blocked2", in_ready, 0);
    tick;
`endif
    chk("bp_still_pc", out_pc, 32'h3000);
    chk("bp_still_valid", out_valid, 1);
    out_ready = 1'b1;
`ifndef PIPE_STAGE_SKID_EN
    #1 chk("bp_release_ready", in_ready, 1);
`endif
    tick;
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_pc", out_pc, 32'h3004);
    chk("bp_second_data", out_data, 32'hB4);
    tick;
    chk("bp_empty", out_valid, 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h3008;
    in_data   = 32'hD8;
    tick;
    in_valid = 1'b0;
    chk("st_loaded", out_pc, 32'h3008);
    stall = 1'b1;
    #1 chk("st_out_valid", out_valid, 0);
    chk("st_in_ready", in_ready, 0);
    repeat (5) tick;
    chk("st_cnt", stall_cnt, 5);
    chk("st_pc", out_pc, 32'h3008);
    chk("st_data", out_data, 32'hD8);
    chk("st_out_valid5", out_valid, 0);
    stall = 1'b0;
    #1 chk("st_resume_valid", out_valid, 1);
    chk("st_resume_pc", out_pc, 32'h3008);

    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'h300C;
    in_data  = 32'hDC;
    #1 chk("fl_in_ready", in_ready, 1);
    chk("fl_out_valid", out_valid, 0);
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid_next", out_valid, 0);
    chk("fl_out_pc", out_pc, 0);
    chk("fl_out_data", out_data, 0);
    out_ready = 1'b1;
    tick;
    chk("fl_nothing", out_valid, 0);
    chk("fl_cnt_kept", stall_cnt, 5);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h3010;
    tick;
    in_valid = 1'b0;
    stall    = 1'b1;
    repeat (9) tick;
    chk("sat_14", stall_cnt_s, 14);
    tick;
    chk("sat_15", stall_cnt_s, 15);
    repeat (10) tick;
    chk("sat_hold", stall_cnt_s, 15);
    chk("sat_wide", stall_cnt, 25);
    stall = 1'b0;
    #1 chk("pre_rst_valid", out_valid, 1);
    res = 1'b0;
    #1 chk("arst_valid", out_valid, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_cnt", stall_cnt, 0);
    chk("arst_in_ready", in_ready, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register carrying a PC and an instruction/data word between adjacent CPU pipeline stages (F→D, D→E, …). It generalises the fixed 32-bit enable-gated stage register with a valid/ready handshake, explicit stall and flush controls, configurable widths, and a saturating stall-cycle counter. An optional skid-buffer mode breaks the combinational ready path for timing closure.

## Interface
- `DATA_W`, 32: instruction/payload width.
- `PC_W`, 32: PC width.
- `RESET_PC`, 0: value driven on `out_pc` after reset or flush.
- `NOP_WORD`, 0: value driven on `out_data` after reset or flush.
- `CNT_W`, 16: stall counter width.

- `clk`  in  1  clock, rising-edge.
- `res`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream has a word.
- `in_ready`  out  1  stage accepts this cycle.
- `in_pc`  in  PC_W  upstream PC.
- `in_data`  in  DATA_W  upstream word.
- `stall`  in  1  hazard hold: freeze both sides.
- `flush`  in  1  discard all held and incoming content.
- `out_valid`  out  1  stage presents a word.
- `out_ready`  in  1  downstream consumes.
- `out_pc`  out  PC_W  held PC.
- `out_data`  out  DATA_W  held word.
- `stall_cnt`  out  CNT_W  saturating count of stalled-while-occupied cycles.

## Operation
- Events: `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Priority per cycle: reset > flush > stall > normal.
- Flush: all entries invalidated, `out_pc` ← `RESET_PC`, `out_data` ← `NOP_WORD`. `in_ready` = 1 and the incoming word is discarded. `out_valid` = 0 during the flush cycle.
- Stall (no flush): `in_ready` = 0, `out_valid` = 0. Internal valid and payload hold.
- Normal, single-entry mode:
  - `in_ready = ~valid_q | out_ready`.
  - On `in_fire`, load payload and set valid.
  - On `out_fire` without `in_fire`, clear valid; payload holds its last value.
  - Simultaneous `in_fire` and `out_fire` is a pass-through: new word loaded, valid stays 1.
- `stall_cnt`: +1 on each cycle with `stall & valid_q & ~flush`. Saturates at all-ones, never wraps. Cleared only by reset.
- Order is strictly FIFO; no word is duplicated or dropped except by flush.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `out_valid` = 0, `out_pc` = `RESET_PC`, `out_data` = `NOP_WORD`, `stall_cnt` = 0.
  - `in_ready` = 0 while `res` is low, 1 from the first cycle after release.
- Latency: a word accepted in cycle N is presented on `out_*` in cycle N+1.
- Throughput: 1 word/cycle when `out_ready` stays high.
- Reset mid-transfer: all content is lost immediately, outputs take reset values asynchronously.
- Deasserting `stall`: `out_valid` reappears the same cycle if an entry is held.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - Adds a second (skid) entry. `in_ready = ~skid_valid_q & ~stall & ~flush_guard`, a purely registered term with no combinational path from `out_ready`.
  - A word accepted while the main entry is full and not draining goes to skid. It moves to main on the next `out_fire`.
  - Full = both entries valid.
  - Flush clears both entries.
  - Latency stays at 1 cycle.
- Undefined: single entry as described above; `in_ready` depends combinationally on `out_ready`.

## Structure
- Shared package `pipe_pkg` holds:
  - `pipe_word_t`, a packed struct of pc and data, parametrised by width localparams.
  - Default `NOP_WORD` and `RESET_PC` constants shared by all stage instances.
- Sub-module `pipe_skid_buf`: the two-entry main/skid storage with occupancy logic. Instantiated only under `PIPE_STAGE_SKID_EN`.
- Top level owns the stall/flush gating and `stall_cnt`.

## Test plan
- Reset: hold `res`=0 with `in_valid`=1, `in_pc`=0x3000, then release → `out_valid`=0, `out_pc`=0, `stall_cnt`=0. One cycle after release, `in_ready`=1.
- Streaming: 8 words, PCs 0x3000..0x301C, `out_ready`=1 throughout → each appears exactly one cycle after acceptance, in order, no gaps.
- Backpressure: present 0x3000 then 0x3004 with `out_ready`=0 for 3 cycles.
  - Single-entry mode: `in_ready`=0 after the first word.
  - Skid mode: both words accepted, then `in_ready`=0.
  - Release `out_ready` → 0x3000 then 0x3004 delivered, nothing lost.
- Stall: hold an entry at 0x3008, assert `stall` for 5 cycles → `out_valid`=0, `in_ready`=0, `stall_cnt`=5, payload unchanged. Deassert → 0x3008 delivered.
- Flush with simultaneous `in_fire` of 0x300C while holding 0x3008 → next cycle `out_valid`=0, `out_pc`=`RESET_PC`, `out_data`=`NOP_WORD`, and neither word is ever emitted.
- Saturation: `CNT_W`=4, stall while occupied for 20 cycles → `stall_cnt` reaches 15 and stays there.
